// File: rtl/psa_result_fifo_pkg.sv
// Shared types and sizing helpers for the PSA result buffer.
// Default widths match the 16-bit parallel sub-word adder output.
package psa_pkg;

  localparam int PSA_DATA_W = 16;
  localparam int PSA_TAG_W  = 4;

  typedef struct packed {
    logic [PSA_DATA_W-1:0] sum;
    logic                  err;
    logic [PSA_TAG_W-1:0]  tag;
  } psa_result_t;

  // Pointer width for a power-of-two depth; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/psa_result_fifo_if.sv
// Execute-to-writeback handshake bundle carried through the result FIFO.
// master drives results in and consumes the head; slave is the FIFO itself.
interface psa_result_fifo_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_err;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_err;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_sum, in_err, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_sum, in_err, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_err, out_tag
  );

endinterface

// File: rtl/psa_result_fifo_sat_counter.sv
// Event counter with synchronous clear and saturating increment.
// A clear and an increment in the same cycle leave the count at one.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    base       = clr ? '0 : count;
    count_next = base;
    if (inc && (base != {CNT_W{1'b1}}))
      count_next = base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/psa_result_fifo.sv
// In-order buffer between PSA execute and register writeback, with sticky
// error flag and saturating error-event counter for control software.
module psa_result_fifo
  import psa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = PSA_DATA_W,
  parameter int TAG_W  = PSA_TAG_W,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  psa_result_fifo_if.slave           bus,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic                       err_sticky,
  output logic [CNT_W-1:0]           err_count,
  output logic [ptr_width(DEPTH):0]  level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Same layout as psa_result_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              err;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic               err_push;

  assign bus.in_ready  = (level != LVL_W'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign err_push      = push & bus.in_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= '{sum: bus.in_sum, err: bus.in_err, tag: bus.in_tag};
  end

  assign head        = mem[rd_ptr];
  assign bus.out_sum = bus.out_valid ? head.sum : '0;
  assign bus.out_err = bus.out_valid ? head.err : 1'b0;
  assign bus.out_tag = bus.out_valid ? head.tag : '0;

  // Error tracking sees every accepted push, including one dropped by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else
      err_sticky <= (err_sticky & ~clr_err) | err_push;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_err),
    .inc   (err_push),
    .count (err_count)
  );

endmodule

// File: tb/tb_psa_result_fifo.sv
// Directed bench for psa_result_fifo: a default instance plus a CNT_W=2
// instance for counter saturation.
module tb_psa_result_fifo;
  import psa_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush0, clr0, flush1, clr1;
  logic       sticky0, sticky1;
  logic [7:0] count0;
  logic [1:0] count1;
  logic [2:0] level0, level1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  psa_result_fifo_if #(.DATA_W(16), .TAG_W(4)) bus0 ();
  psa_result_fifo_if #(.DATA_W(16), .TAG_W(4)) bus1 ();

  psa_result_fifo #(.DEPTH(4), .DATA_W(16), .TAG_W(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .flush(flush0), .clr_err(clr0),
    .err_sticky(sticky0), .err_count(count0), .level(level0)
  );

  psa_result_fifo #(.DEPTH(4), .DATA_W(16), .TAG_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .flush(flush1), .clr_err(clr1),
    .err_sticky(sticky1), .err_count(count1), .level(level1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush0 = 0; clr0 = 0; flush1 = 0; clr1 = 0;
    bus0.in_valid = 0; bus0.in_sum = '0; bus0.in_err = 0; bus0.in_tag = '0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.in_sum = '0; bus1.in_err = 0; bus1.in_tag = '0; bus1.out_ready = 0;
    #12;
    check("rst_level", 32'(level0), 0);
    check("rst_out_valid", 32'(bus0.out_valid), 0);
    check("rst_out_sum", 32'(bus0.out_sum), 0);
    check("rst_sticky", 32'(sticky0), 0);
    check("rst_count", 32'(count0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus0.in_ready), 1);

    // single entry latency and output gating
    bus0.in_valid = 1; bus0.in_sum = 16'h1234; bus0.in_err = 0; bus0.in_tag = 4'd3;
    step();
    bus0.in_valid = 0;
    check("t1_out_valid", 32'(bus0.out_valid), 1);
    check("t1_out_sum", 32'(bus0.out_sum), 32'h1234);
    check("t1_out_tag", 32'(bus0.out_tag), 3);
    check("t1_level", 32'(level0), 1);
    bus0.out_ready = 1;
    step();
    bus0.out_ready = 0;
    check("t1_pop_valid", 32'(bus0.out_valid), 0);
    check("t1_pop_sum", 32'(bus0.out_sum), 0);
    check("t1_pop_tag", 32'(bus0.out_tag), 0);
    check("t1_pop_level", 32'(level0), 0);

    // fill to full, hold a fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid = 1; bus0.in_sum = 16'hA000 + 16'(i); bus0.in_tag = 4'(i);
      step();
    end
    check("t2_full_level", 32'(level0), 4);
    check("t2_full_ready", 32'(bus0.in_ready), 0);
    bus0.in_sum = 16'hA004;
    bus0.out_ready = 0;
    step();
    check("t2_held_level", 32'(level0), 4);
    check("t2_held_head", 32'(bus0.out_sum), 32'hA000);
    bus0.in_valid = 0;
    bus0.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain%0d", i), 32'(bus0.out_sum), 32'hA000 + 32'(i));
      step();
    end
    bus0.out_ready = 0;
    check("t2_empty_level", 32'(level0), 0);

    // streaming across pointer wrap with two entries resident
    for (int i = 0; i < 2; i++) begin
      bus0.in_valid = 1; bus0.in_sum = 16'(i);
      step();
    end
    bus0.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      bus0.in_sum = 16'(i + 2);
      check($sformatf("t3_head%0d", i), 32'(bus0.out_sum), 32'(i));
      check($sformatf("t3_level%0d", i), 32'(level0), 2);
      step();
    end
    bus0.in_valid = 0;
    for (int i = 20; i < 22; i++) begin
      check($sformatf("t3_tail%0d", i), 32'(bus0.out_sum), 32'(i));
      step();
    end
    bus0.out_ready = 0;
    check("t3_empty", 32'(level0), 0);

    // error tracking
    bus0.in_valid = 1; bus0.in_err = 1;
    for (int i = 0; i < 3; i++) begin
      bus0.in_sum = 16'hE000 + 16'(i);
      step();
    end
    bus0.in_valid = 0;
    check("t4_sticky", 32'(sticky0), 1);
    check("t4_count3", 32'(count0), 3);
    check("t4_head_err", 32'(bus0.out_err), 1);
    bus0.in_valid = 1; clr0 = 1;
    step();
    clr0 = 0;
    check("t4_clr_push_sticky", 32'(sticky0), 1);
    check("t4_clr_push_count", 32'(count0), 1);
    check("t4_level_full", 32'(level0), 4);
    step();
    bus0.in_valid = 0; bus0.in_err = 0;
    check("t4_full_err_ignored", 32'(count0), 1);
    clr0 = 1;
    step();
    clr0 = 0;
    check("t4_clr_sticky", 32'(sticky0), 0);
    check("t4_clr_count", 32'(count0), 0);
    flush0 = 1;
    step();
    flush0 = 0;
    check("t4_flush_level", 32'(level0), 0);

    // saturation on the 2-bit counter instance
    bus1.out_ready = 1; bus1.in_valid = 1; bus1.in_err = 1;
    for (int i = 0; i < 2; i++) begin
      bus1.in_sum = 16'(i);
      step();
    end
    check("t5_count2", 32'(count1), 2);
    for (int i = 0; i < 3; i++) begin
      bus1.in_sum = 16'(i + 2);
      step();
    end
    bus1.in_valid = 0; bus1.in_err = 0;
    check("t5_saturate", 32'(count1), 3);
    check("t5_sticky", 32'(sticky1), 1);

    // flush together with an error push
    bus0.in_valid = 1; bus0.in_err = 0;
    for (int i = 0; i < 3; i++) begin
      bus0.in_sum = 16'hC000 + 16'(i);
      step();
    end
    check("t6_level3", 32'(level0), 3);
    bus0.in_sum = 16'hC003; bus0.in_err = 1; flush0 = 1;
    step();
    flush0 = 0; bus0.in_valid = 0; bus0.in_err = 0;
    check("t6_flush_level", 32'(level0), 0);
    check("t6_flush_valid", 32'(bus0.out_valid), 0);
    check("t6_flush_count", 32'(count0), 1);
    check("t6_flush_ready", 32'(bus0.in_ready), 1);
    bus0.in_valid = 1; bus0.in_sum = 16'hBEEF; bus0.in_tag = 4'd9;
    step();
    check("t6_after_flush_sum", 32'(bus0.out_sum), 32'hBEEF);
    check("t6_after_flush_tag", 32'(bus0.out_tag), 9);

    // asynchronous reset mid-stream
    bus0.in_sum = 16'hBEF0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_valid", 32'(bus0.out_valid), 0);
    check("t6_arst_sum", 32'(bus0.out_sum), 0);
    check("t6_arst_tag", 32'(bus0.out_tag), 0);
    check("t6_arst_level", 32'(level0), 0);
    check("t6_arst_count", 32'(count0), 0);
    check("t6_arst_count1", 32'(count1), 0);
    bus0.in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_post_rst_ready", 32'(bus0.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
